// File: rtl/obb_sat_check.sv
`default_nettype none
// ============================================================================
// Module   : obb_sat_check
// Purpose  : Sequential 2-D separating-axis overlap test for two oriented
//            bounding boxes, built around one time-multiplexed multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module obb_sat_check #(
    parameter int COORD_W   = 8,
    parameter int AXIS_FRAC = 6,
    parameter int ACC_W     = 28
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic signed [COORD_W-1:0] a_cx_i,
    input  logic signed [COORD_W-1:0] a_cy_i,
    input  logic signed [COORD_W-1:0] a_w_i,
    input  logic signed [COORD_W-1:0] a_h_i,
    input  logic signed [COORD_W-1:0] a_ux_i,
    input  logic signed [COORD_W-1:0] a_uy_i,
    input  logic signed [COORD_W-1:0] b_cx_i,
    input  logic signed [COORD_W-1:0] b_cy_i,
    input  logic signed [COORD_W-1:0] b_w_i,
    input  logic signed [COORD_W-1:0] b_h_i,
    input  logic signed [COORD_W-1:0] b_ux_i,
    input  logic signed [COORD_W-1:0] b_uy_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      hit_o,
    output logic [1:0]                sep_axis_o
);
    localparam int         AX_W      = COORD_W + 1;
    localparam int         TMP_W     = 2 * AX_W + 1;
    localparam int         PRD_W     = TMP_W + AX_W;
    localparam logic [3:0] LAST_STEP = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ACC  = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                step_q, step_d;
    logic [1:0]                k_q, k_d;
    logic signed [ACC_W-1:0]   proj_q, proj_d;
    logic signed [ACC_W-1:0]   rad_q, rad_d;
    logic signed [TMP_W-1:0]   tmp_q, tmp_d;
    logic                      hit_q, hit_d;
    logic [1:0]                sep_q, sep_d;
    // Captured operands: cen = {acx, acy, bcx, bcy}, ext = {aw, ah, bw, bh}, uv = {aux, auy, bux, buy}
    logic signed [COORD_W-1:0] cen_q [4];
    logic signed [COORD_W-1:0] cen_d [4];
    logic signed [COORD_W-1:0] ext_q [4];
    logic signed [COORD_W-1:0] ext_d [4];
    logic signed [COORD_W-1:0] uv_q  [4];
    logic signed [COORD_W-1:0] uv_d  [4];

    logic signed [AX_W-1:0]    ax_x [4];
    logic signed [AX_W-1:0]    ax_y [4];
    logic signed [AX_W-1:0]    dx, dy, lx, ly;
    logic [1:0]                box_j, phase;
    logic signed [TMP_W-1:0]   tmp_abs;
    logic signed [TMP_W-1:0]   op_a;
    logic signed [AX_W-1:0]    op_b;
    logic signed [PRD_W-1:0]   prod;
    logic signed [ACC_W-1:0]   prod_acc;
    logic signed [ACC_W-1:0]   proj_abs, proj_sh;
    logic                      separated;

    function automatic logic signed [COORD_W-1:0] clamp0(input logic signed [COORD_W-1:0] v);
        return v[COORD_W-1] ? '0 : v;
    endfunction

    // Axis table in evaluation order A.u, A.v, B.u, B.v; v = (-uy, ux)
    always_comb begin
        ax_x[0] = AX_W'(uv_q[0]);
        ax_y[0] = AX_W'(uv_q[1]);
        ax_x[1] = -(AX_W'(uv_q[1]));
        ax_y[1] = AX_W'(uv_q[0]);
        ax_x[2] = AX_W'(uv_q[2]);
        ax_y[2] = AX_W'(uv_q[3]);
        ax_x[3] = -(AX_W'(uv_q[3]));
        ax_y[3] = AX_W'(uv_q[2]);
    end

    assign dx = AX_W'(cen_q[2]) - AX_W'(cen_q[0]);
    assign dy = AX_W'(cen_q[3]) - AX_W'(cen_q[1]);
    assign lx = ax_x[k_q];
    assign ly = ax_y[k_q];

    // Steps 2..13 visit box axis j with phase 0 (x term), 1 (y term), 2 (radius term)
    always_comb begin
        box_j = 2'd0;
        phase = 2'd0;
        case (step_q)
            4'd3:    begin box_j = 2'd0; phase = 2'd1; end
            4'd4:    begin box_j = 2'd0; phase = 2'd2; end
            4'd5:    begin box_j = 2'd1; phase = 2'd0; end
            4'd6:    begin box_j = 2'd1; phase = 2'd1; end
            4'd7:    begin box_j = 2'd1; phase = 2'd2; end
            4'd8:    begin box_j = 2'd2; phase = 2'd0; end
            4'd9:    begin box_j = 2'd2; phase = 2'd1; end
            4'd10:   begin box_j = 2'd2; phase = 2'd2; end
            4'd11:   begin box_j = 2'd3; phase = 2'd0; end
            4'd12:   begin box_j = 2'd3; phase = 2'd1; end
            4'd13:   begin box_j = 2'd3; phase = 2'd2; end
            default: begin box_j = 2'd0; phase = 2'd0; end
        endcase
    end

    assign tmp_abs = tmp_q[TMP_W-1] ? -tmp_q : tmp_q;

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (step_q == 4'd0) begin
            op_a = TMP_W'(dx);
            op_b = lx;
        end else if (step_q == 4'd1) begin
            op_a = TMP_W'(dy);
            op_b = ly;
        end else begin
            case (phase)
                2'd0:    begin op_a = TMP_W'(ax_x[box_j]); op_b = lx; end
                2'd1:    begin op_a = TMP_W'(ax_y[box_j]); op_b = ly; end
                default: begin op_a = tmp_abs;             op_b = AX_W'(ext_q[box_j]); end
            endcase
        end
    end

    assign prod     = PRD_W'(op_a) * PRD_W'(op_b);
    assign prod_acc = ACC_W'(prod);

    // Strict compare: touching boxes count as overlapping
    assign proj_abs  = proj_q[ACC_W-1] ? -proj_q : proj_q;
    assign proj_sh   = proj_abs <<< AXIS_FRAC;
    assign separated = proj_sh > rad_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        k_d     = k_q;
        proj_d  = proj_q;
        rad_d   = rad_q;
        tmp_d   = tmp_q;
        hit_d   = hit_q;
        sep_d   = sep_q;
        cen_d   = cen_q;
        ext_d   = ext_q;
        uv_d    = uv_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    cen_d   = '{a_cx_i, a_cy_i, b_cx_i, b_cy_i};
                    ext_d   = '{clamp0(a_w_i), clamp0(a_h_i), clamp0(b_w_i), clamp0(b_h_i)};
                    uv_d    = '{a_ux_i, a_uy_i, b_ux_i, b_uy_i};
                    hit_d   = 1'b0;
                    sep_d   = 2'd0;
                end
            end
            S_LOAD: begin
                state_d = S_ACC;
                step_d  = 4'd0;
                k_d     = 2'd0;
                proj_d  = '0;
                rad_d   = '0;
                tmp_d   = '0;
            end
            S_ACC: begin
                step_d = step_q + 4'd1;
                if (step_q <= 4'd1) begin
                    proj_d = proj_q + prod_acc;
                end else begin
                    case (phase)
                        2'd0:    tmp_d = TMP_W'(prod);
                        2'd1:    tmp_d = tmp_q + TMP_W'(prod);
                        default: rad_d = rad_q + prod_acc;
                    endcase
                end
                if (step_q == LAST_STEP) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (separated) begin
                    hit_d   = 1'b0;
                    sep_d   = k_q;
                    state_d = S_DONE;
                end else if (k_q == 2'd3) begin
                    hit_d   = 1'b1;
                    sep_d   = 2'd0;
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 2'd1;
                    step_d  = 4'd0;
                    proj_d  = '0;
                    rad_d   = '0;
                    tmp_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            k_q     <= '0;
            proj_q  <= '0;
            rad_q   <= '0;
            tmp_q   <= '0;
            hit_q   <= 1'b0;
            sep_q   <= '0;
            cen_q   <= '{default: '0};
            ext_q   <= '{default: '0};
            uv_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            k_q     <= k_d;
            proj_q  <= proj_d;
            rad_q   <= rad_d;
            tmp_q   <= tmp_d;
            hit_q   <= hit_d;
            sep_q   <= sep_d;
            cen_q   <= cen_d;
            ext_q   <= ext_d;
            uv_q    <= uv_d;
        end
    end

    assign busy_o     = (state_q == S_LOAD) || (state_q == S_ACC) || (state_q == S_CMP);
    assign done_o     = (state_q == S_DONE);
    assign hit_o      = hit_q;
    assign sep_axis_o = sep_q;

endmodule
`default_nettype wire
